// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle main control sequencer: states, opcodes,
// ALU operation classes, mux selects and the packed control word.
package ctrl_pkg;

   localparam int unsigned STATE_W = 4;
   localparam int unsigned OP_W    = 6;
   localparam int unsigned ALUOP_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_I_EXEC    = 4'd8,
      S_I_WB      = 4'd9,
      S_BRANCH    = 4'd10,
      S_JUMP      = 4'd11,
      S_ERROR     = 4'd12
   } state_t;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
   localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;

   localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b000;
   localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
   localparam logic [ALUOP_W-1:0] ALU_RTYPE = 3'b010;
   localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b011;
   localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b100;
   localparam logic [ALUOP_W-1:0] ALU_SLT   = 3'b111;

   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic                pc_write;
      logic                pc_write_cond;
      logic                i_or_d;
      logic                mem_read;
      logic                mem_write;
      logic                ir_write;
      logic                mem_to_reg;
      logic                reg_dst;
      logic                reg_write;
      logic                alu_src_a;
      logic [1:0]          alu_src_b;
      logic [1:0]          pc_source;
      logic [ALUOP_W-1:0]  alu_op;
      logic                illegal_op;
   } ctrl_word_t;

   localparam int unsigned CTRL_W = $bits(ctrl_word_t);

   // ALU class for the immediate-arithmetic group
   function automatic logic [ALUOP_W-1:0] imm_alu_op(input logic [OP_W-1:0] op);
      case (op)
         OP_ANDI: return ALU_AND;
         OP_ORI:  return ALU_OR;
         OP_SLTI: return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational control-word decode from the current state, latched opcode
// and the memory-ready handshake (FETCH only).
module ctrl_output_decode
   import ctrl_pkg::*;
(
   input  logic [STATE_W-1:0] state,
   input  logic [OP_W-1:0]    op_latched,
   input  logic               mem_ready,
   output logic [CTRL_W-1:0]  ctrl
);

   ctrl_word_t cw;

   always_comb begin
      cw = '0;
      case (state_t'(state))
         S_FETCH: begin
            cw.mem_read  = 1'b1;
            cw.alu_src_b = SRCB_FOUR;
            cw.alu_op    = ALU_ADD;
            cw.pc_source = PCSRC_ALU;
            cw.ir_write  = mem_ready;
            cw.pc_write  = mem_ready;
         end
         S_DECODE: begin
            cw.alu_src_b = SRCB_IMM_SH2;
            cw.alu_op    = ALU_ADD;
         end
         S_MEM_ADDR: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRCB_IMM;
            cw.alu_op    = ALU_ADD;
         end
         S_MEM_READ: begin
            cw.mem_read = 1'b1;
            cw.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            cw.reg_write  = 1'b1;
            cw.mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            cw.mem_write = 1'b1;
            cw.i_or_d    = 1'b1;
         end
         S_R_EXEC: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRCB_RT;
            cw.alu_op    = ALU_RTYPE;
         end
         S_R_WB: begin
            cw.reg_write = 1'b1;
            cw.reg_dst   = 1'b1;
         end
         S_I_EXEC: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRCB_IMM;
            cw.alu_op    = imm_alu_op(op_latched);
         end
         S_I_WB: cw.reg_write = 1'b1;
         S_BRANCH: begin
            cw.alu_src_a     = 1'b1;
            cw.alu_src_b     = SRCB_RT;
            cw.alu_op        = ALU_SUB;
            cw.pc_write_cond = 1'b1;
            cw.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            cw.pc_write  = 1'b1;
            cw.pc_source = PCSRC_JUMP;
         end
         S_ERROR: cw.illegal_op = 1'b1;
         default: cw = '0;
      endcase
   end

   assign ctrl = cw;

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle main control sequencer: state register, opcode latch and
// retired-instruction counter around the combinational control decode.
module main_control_fsm
   import ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 16
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       pc_source,
   output logic [2:0]       ALUOpcode,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instr_count,
   output logic [3:0]       state
);

   state_t            state_q, state_d;
   logic [OP_W-1:0]   opcode_q;
   logic [CNT_W-1:0]  count_q;
   logic              retire;
   logic [CTRL_W-1:0] ctrl_raw;
   ctrl_word_t        cw;

   // zero is consumed by the datapath's conditional PC write, not by sequencing
   logic unused_zero;
   assign unused_zero = zero;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_FETCH;
         opcode_q <= '0;
         count_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) opcode_q <= opcode;
         if (retire) count_q <= count_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
               OP_RTYPE:                          state_d = S_R_EXEC;
               OP_BEQ:                            state_d = S_BRANCH;
               OP_J:                              state_d = S_JUMP;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EXEC;
               default:                           state_d = S_ERROR;
            endcase
         end
         S_MEM_ADDR: state_d = (opcode_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ: if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WRITE: begin
            if (mem_ready) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_R_EXEC:   state_d = S_R_WB;
         S_I_EXEC:   state_d = S_I_WB;
         S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_ERROR:    state_d = S_ERROR;
         default:    state_d = S_FETCH;
      endcase
   end

   ctrl_output_decode u_decode (
      .state      (state_q),
      .op_latched (opcode_q),
      .mem_ready  (mem_ready),
      .ctrl       (ctrl_raw)
   );

   // Reset blanks every output immediately, before the state register updates
   assign cw            = reset ? '0 : ctrl_word_t'(ctrl_raw);
   assign pc_write      = cw.pc_write;
   assign pc_write_cond = cw.pc_write_cond;
   assign i_or_d        = cw.i_or_d;
   assign mem_read      = cw.mem_read;
   assign mem_write     = cw.mem_write;
   assign ir_write      = cw.ir_write;
   assign mem_to_reg    = cw.mem_to_reg;
   assign reg_dst       = cw.reg_dst;
   assign reg_write     = cw.reg_write;
   assign alu_src_a     = cw.alu_src_a;
   assign alu_src_b     = cw.alu_src_b;
   assign pc_source     = cw.pc_source;
   assign ALUOpcode     = cw.alu_op;
   assign illegal_op    = cw.illegal_op;
   assign instr_count   = reset ? '0 : count_q;
   assign state         = reset ? 4'd0 : state_q;

endmodule
